// File: rtl/sram_axi4_burst.sv
// AXI4 slave SRAM: independent read/write burst FSMs over a 1R1W word array.
// Optional SRAM_AXI4_MEM_INIT_EN: after reset, sweep mem[i] = i before accepting requests.
module sram_axi4_burst #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 256,
    parameter int ID_W   = 4
) (
    input  logic                  i_aclk,
    input  logic                  i_areset,
    input  logic [ID_W-1:0]       i_arid,
    input  logic [ADDR_W-1:0]     i_araddr,
    input  logic [7:0]            i_arlen,
    input  logic [2:0]            i_arsize,
    input  logic [1:0]            i_arburst,
    input  logic                  i_arvalid,
    output logic                  o_arready,
    output logic [ID_W-1:0]       o_rid,
    output logic [DATA_W-1:0]     o_rdata,
    output logic [1:0]            o_rresp,
    output logic                  o_rlast,
    output logic                  o_rvalid,
    input  logic                  i_rready,
    input  logic [ID_W-1:0]       i_awid,
    input  logic [ADDR_W-1:0]     i_awaddr,
    input  logic [7:0]            i_awlen,
    input  logic [2:0]            i_awsize,
    input  logic [1:0]            i_awburst,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_wstrb,
    input  logic                  i_wlast,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    output logic [ID_W-1:0]       o_bid,
    output logic [1:0]            o_bresp,
    output logic                  o_bvalid,
    input  logic                  i_bready
);
    localparam int BYTES  = DATA_W / 8;
    localparam int LSB    = $clog2(BYTES);
    localparam int DIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);
`ifdef SRAM_AXI4_MEM_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [7:0] len,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] wmask;
        wmask = ADDR_W'((32'(len) + 32'd1) * BYTES - 1);
        case (burst)
            BURST_FIXED: step_addr = a;
            BURST_WRAP:  step_addr = (a & ~wmask) | ((a + ADDR_W'(BYTES)) & wmask);
            default:     step_addr = a + ADDR_W'(BYTES);
        endcase
    endfunction

    function automatic logic burst_err(input logic [2:0] size, input logic [7:0] len,
                                       input logic [1:0] burst);
        burst_err = (size != 3'(LSB)) ||
                    ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    function automatic logic idx_oob(input logic [ADDR_W-1:0] a);
        idx_oob = (32'(a >> LSB) >= 32'(DEPTH));
    endfunction

    function automatic logic [DIDX_W-1:0] word_sel(input logic [ADDR_W-1:0] a);
        word_sel = DIDX_W'(a >> LSB);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic              init_busy;
    logic              init_last;
    logic [DIDX_W-1:0] init_idx;

`ifdef SRAM_AXI4_MEM_INIT_EN
    logic              init_busy_q;
    logic [DIDX_W-1:0] init_cnt_q;

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            init_busy_q <= 1'b1;
            init_cnt_q  <= '0;
        end else if (init_busy_q) begin
            init_cnt_q <= init_cnt_q + DIDX_W'(1);
            if (init_last) init_busy_q <= 1'b0;
        end
    end

    assign init_busy = init_busy_q;
    assign init_idx  = init_cnt_q;
    assign init_last = init_busy_q && (32'(init_cnt_q) == 32'(DEPTH - 1));
`else
    assign init_busy = 1'b0;
    assign init_idx  = '0;
    assign init_last = 1'b0;
`endif

    // ---------------- read channel ----------------
    typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_DATA} rd_state_e;
    rd_state_e         rd_state_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [7:0]        rd_len_q, rd_cnt_q;
    logic [1:0]        rd_burst_q;
    logic              rd_berr_q;
    logic              arready_q, rvalid_q, rlast_q;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;

    logic              rd_adv;
    logic [ADDR_W-1:0] rd_src_addr;
    logic              rd_beat_err;
    logic [DATA_W-1:0] rd_word;

    // The next beat is looked up from the stepped address so an accepted beat is replaced on the same edge.
    always_comb begin
        rd_adv      = (rd_state_q == RD_DATA) && i_rready && !rlast_q;
        rd_src_addr = rd_adv ? step_addr(rd_addr_q, rd_len_q, rd_burst_q) : rd_addr_q;
        rd_beat_err = rd_berr_q || idx_oob(rd_src_addr);
        rd_word     = rd_beat_err ? '0 : mem[word_sel(rd_src_addr)];
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= !INIT_EN;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rid_q      <= '0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_cnt_q   <= '0;
            rd_burst_q <= '0;
            rd_berr_q  <= 1'b0;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (arready_q && i_arvalid) begin
                        rd_addr_q  <= i_araddr & ALIGN_MASK;
                        rd_len_q   <= i_arlen;
                        rd_burst_q <= i_arburst;
                        rd_berr_q  <= burst_err(i_arsize, i_arlen, i_arburst);
                        rid_q      <= i_arid;
                        arready_q  <= 1'b0;
                        rd_state_q <= RD_FETCH;
                    end else begin
                        arready_q <= !init_busy || init_last;
                    end
                end
                RD_FETCH: begin
                    rdata_q    <= rd_word;
                    rresp_q    <= rd_beat_err ? RESP_SLVERR : RESP_OKAY;
                    rlast_q    <= (rd_len_q == 8'd0);
                    rvalid_q   <= 1'b1;
                    rd_cnt_q   <= '0;
                    rd_state_q <= RD_DATA;
                end
                RD_DATA: begin
                    if (i_rready) begin
                        if (rlast_q) begin
                            rvalid_q   <= 1'b0;
                            rlast_q    <= 1'b0;
                            arready_q  <= 1'b1;
                            rd_state_q <= RD_IDLE;
                        end else begin
                            rd_addr_q <= rd_src_addr;
                            rdata_q   <= rd_word;
                            rresp_q   <= rd_beat_err ? RESP_SLVERR : RESP_OKAY;
                            rd_cnt_q  <= rd_cnt_q + 8'd1;
                            rlast_q   <= ((rd_cnt_q + 8'd1) == rd_len_q);
                        end
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    // ---------------- write channel ----------------
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;
    wr_state_e         wr_state_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_len_q, wr_cnt_q;
    logic [1:0]        wr_burst_q;
    logic              wr_berr_q, wr_err_q;
    logic [ID_W-1:0]   wr_id_q;
    logic              awready_q, wready_q, bvalid_q;
    logic [1:0]        bresp_q;
    logic [ID_W-1:0]   bid_q;

    logic wr_hs, wr_beat_last, wr_mem_ok, wr_beat_err;

    always_comb begin
        wr_hs        = (wr_state_q == WR_DATA) && wready_q && i_wvalid;
        wr_beat_last = (wr_cnt_q == wr_len_q);
        wr_mem_ok    = !wr_berr_q && !idx_oob(wr_addr_q);
        wr_beat_err  = !wr_mem_ok || (i_wlast != wr_beat_last);
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= !INIT_EN;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            bid_q      <= '0;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            wr_cnt_q   <= '0;
            wr_burst_q <= '0;
            wr_berr_q  <= 1'b0;
            wr_err_q   <= 1'b0;
            wr_id_q    <= '0;
        end else begin
            case (wr_state_q)
                WR_IDLE: begin
                    if (awready_q && i_awvalid) begin
                        wr_addr_q  <= i_awaddr & ALIGN_MASK;
                        wr_len_q   <= i_awlen;
                        wr_burst_q <= i_awburst;
                        wr_berr_q  <= burst_err(i_awsize, i_awlen, i_awburst);
                        wr_id_q    <= i_awid;
                        wr_cnt_q   <= '0;
                        wr_err_q   <= 1'b0;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        wr_state_q <= WR_DATA;
                    end else begin
                        awready_q <= !init_busy || init_last;
                    end
                end
                WR_DATA: begin
                    if (wr_hs) begin
                        if (wr_beat_last) begin
                            wready_q   <= 1'b0;
                            bvalid_q   <= 1'b1;
                            bresp_q    <= (wr_err_q || wr_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            bid_q      <= wr_id_q;
                            wr_state_q <= WR_RESP;
                        end else begin
                            wr_cnt_q  <= wr_cnt_q + 8'd1;
                            wr_addr_q <= step_addr(wr_addr_q, wr_len_q, wr_burst_q);
                            wr_err_q  <= wr_err_q || wr_beat_err;
                        end
                    end
                end
                WR_RESP: begin
                    if (i_bready) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wr_state_q <= WR_IDLE;
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    // ---------------- memory write port ----------------
    logic              mem_we;
    logic [DIDX_W-1:0] mem_widx;
    logic [DATA_W-1:0] mem_wdata;
    logic [BYTES-1:0]  mem_wstrb;

    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (init_busy) begin
            mem_we    = 1'b1;
            mem_widx  = init_idx;
            mem_wdata = DATA_W'(init_idx);
            mem_wstrb = '1;
        end else if (wr_hs && wr_mem_ok) begin
            mem_we    = 1'b1;
            mem_widx  = word_sel(wr_addr_q);
            mem_wdata = i_wdata;
            mem_wstrb = i_wstrb;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (mem_we && !i_areset) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (mem_wstrb[b]) mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    assign o_arready = arready_q;
    assign o_rid     = rid_q;
    assign o_rdata   = rdata_q;
    assign o_rresp   = rresp_q;
    assign o_rlast   = rlast_q;
    assign o_rvalid  = rvalid_q;
    assign o_awready = awready_q;
    assign o_wready  = wready_q;
    assign o_bid     = bid_q;
    assign o_bresp   = bresp_q;
    assign o_bvalid  = bvalid_q;

endmodule
